spart_txq: RTL and testbench

SPART_TXQ -- requirements
Module: spart_txq

---
 rtl/spart_pkg.sv | 30 +++
 rtl/spart_txq_fifo.sv | 53 +++++
 rtl/spart_txq.sv | 165 ++++++++++++++++
 tb/tb_spart_txq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared types and limits for the SPART transmit queue: FSM states, parity modes, parameter ranges.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } par_mode_t;

  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 8;
  localparam int DEPTH_MIN     = 2;
  localparam int DEPTH_MAX     = 16;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  function automatic logic par_active(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/spart_txq_fifo.sv
// Transmit character FIFO; head visible combinationally, push/pop/level update on the same edge.
// A push while full is dropped even if a pop happens that cycle.
module spart_txq_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spart_txq.sv
// SPART transmitter with character FIFO; frames start + DATA_W data (LSB first) + optional parity + stop.
// Parity support and the par_mode port are built only when SPART_TXQ_PARITY_EN is defined.
module spart_txq
  import spart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rate_en,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
`ifdef SPART_TXQ_PARITY_EN
  input  logic [1:0]               par_mode,
`endif
  output logic                     txd,
  output logic                     tbr,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("spart_txq: DATA_W out of range");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("spart_txq: DEPTH must be a power of two in range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("spart_txq: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [CW-1:0]     bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              last_stop;
  logic              pop;
  logic              go_par;
  logic              par_bit;

  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign pop = rate_en && !empty && ((state == IDLE) || (state == STOP && last_stop));
  assign tbr = ~full;

  spart_txq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

`ifdef SPART_TXQ_PARITY_EN
  logic par_on;
  logic par_acc;

  // Mode is latched at pop; the accumulator starts at 1 for odd so the final XOR yields the complement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_on  <= 1'b0;
      par_acc <= 1'b0;
    end else if (pop) begin
      par_on  <= par_active(par_mode);
      par_acc <= (par_mode == PAR_ODD);
    end else if (rate_en && state == DATA) begin
      par_acc <= par_acc ^ shift[0];
    end
  end

  assign go_par  = par_on;
  assign par_bit = par_acc ^ shift[0];
`else
  assign go_par  = 1'b0;
  assign par_bit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      shift    <= '1;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ovf <= wr_en && full;
      if (rate_en) begin
        case (state)
          IDLE: begin
            if (!empty) begin
              shift <= head;
              state <= START;
              txd   <= 1'b0;
              busy  <= 1'b1;
            end
          end
          START: begin
            bit_cnt <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end
          DATA: begin
            shift   <= {1'b1, shift[DATA_W-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              if (go_par) begin
                state <= PARITY;
                txd   <= par_bit;
              end else begin
                state    <= STOP;
                txd      <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              txd <= shift[1];
            end
          end
          PARITY: begin
            state    <= STOP;
            txd      <= 1'b1;
            stop_cnt <= 1'b0;
          end
          STOP: begin
            if (last_stop) begin
              // Chain straight into the next start bit so queued frames leave no idle gap.
              if (!empty) begin
                shift <= head;
                state <= START;
                txd   <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spart_txq.sv
// Scoreboarded bench for spart_txq: stimulus queues expected line bits, per-DUT monitors check each bit.
module tb_spart_txq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rcnt = 4'd0;
  logic       rate_en;

  always #5 clk = ~clk;
  always @(posedge clk) rcnt <= rcnt + 4'd1;
  assign rate_en = (rcnt == 4'd15);

  logic       wr_en_a = 1'b0;
  logic [7:0] wr_data_a = 8'h00;
  logic       txd_a, tbr_a, busy_a, ovf_a;
  logic [2:0] level_a;
  logic       wr_en_b = 1'b0;
  logic [4:0] wr_data_b = 5'h00;
  logic       txd_b, tbr_b, busy_b, ovf_b;
  logic [2:0] level_b;
`ifdef SPART_TXQ_PARITY_EN
  logic [1:0] par_mode_a = 2'b00;
  logic [1:0] par_mode_b = 2'b00;
`endif

  spart_txq #(.DATA_W(8), .DEPTH(4), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .rate_en(rate_en), .wr_en(wr_en_a), .wr_data(wr_data_a),
`ifdef SPART_TXQ_PARITY_EN
    .par_mode(par_mode_a),
`endif
    .txd(txd_a), .tbr(tbr_a), .busy(busy_a), .level(level_a), .ovf(ovf_a)
  );

  spart_txq #(.DATA_W(5), .DEPTH(4), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .rate_en(rate_en), .wr_en(wr_en_b), .wr_data(wr_data_b),
`ifdef SPART_TXQ_PARITY_EN
    .par_mode(par_mode_b),
`endif
    .txd(txd_b), .tbr(tbr_b), .busy(busy_b), .level(level_b), .ovf(ovf_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovf_cnt_a = 0;
  logic exp_a[$];
  logic exp_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_vec_a(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_a.push_back(v[i]);
  endtask

  task automatic push_vec_b(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_b.push_back(v[i]);
  endtask

  // Reference framing for DUT A: start, data LSB first, parity if selected, one stop.
  task automatic frame_a(input logic [7:0] d);
    exp_a.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_a.push_back(d[i]);
`ifdef SPART_TXQ_PARITY_EN
    if (par_mode_a == 2'b01) exp_a.push_back(^d);
    if (par_mode_a == 2'b10) exp_a.push_back(~(^d));
`endif
    exp_a.push_back(1'b1);
  endtask

  logic sv_a, sv_b, e_a, e_b;
  bit   pend_a = 0, pend_b = 0;

  always @(negedge clk) begin
    if (rst) pend_a = 0;
    else begin
      if (pend_a) begin sv_a = txd_a; pend_a = 0; end
      if (rate_en && busy_a) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_bit: got txd=%0b, expected no frame bit at %0t", txd_a, $time);
        end else begin
          e_a = exp_a.pop_front();
          chk("a_bit_end", txd_a, e_a);
          chk("a_bit_start", sv_a, e_a);
        end
      end
      if (rate_en) pend_a = 1;
    end
  end

  always @(negedge clk) begin
    if (rst) pend_b = 0;
    else begin
      if (pend_b) begin sv_b = txd_b; pend_b = 0; end
      if (rate_en && busy_b) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_bit: got txd=%0b, expected no frame bit at %0t", txd_b, $time);
        end else begin
          e_b = exp_b.pop_front();
          chk("b_bit_end", txd_b, e_b);
          chk("b_bit_start", sv_b, e_b);
        end
      end
      if (rate_en) pend_b = 1;
    end
  end

  always @(negedge clk) if (ovf_a === 1'b1) ovf_cnt_a++;

  task automatic align();
    @(negedge clk);
    while (!rate_en) @(negedge clk);
  endtask

  task automatic wait_rate(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (!rate_en) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int which);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (which == 0) done = (exp_a.size() == 0) && !busy_a && (level_a == 3'd0);
      else            done = (exp_b.size() == 0) && !busy_b && (level_b == 3'd0);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: dut %0d still busy, expected idle within 3000 cycles", which);
    end
  endtask

  task automatic busy_len(input int which, output int n);
    bit b;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      b = (which == 0) ? busy_a : busy_b;
      if (b) n++;
      else if (n > 0) break;
    end
  endtask

  int o0, nb;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd_a", txd_a, 1);
    chk("rst_level_a", level_a, 0);
    chk("rst_tbr_a", tbr_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_txd_b", txd_b, 1);
    rst = 1'b0;

    // 0x55 alternating frame; nothing leaves before the next tick
    align(); @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h55; push_vec_a(16'b0101010101, 10);
    @(negedge clk); wr_en_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_pre_tick_busy", busy_a, 0);
    chk("a_pre_tick_txd", txd_a, 1);
    chk("a_pre_tick_level", level_a, 1);
    wait_idle(0);
    chk("a_idle_txd", txd_a, 1);

    align(); @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'hA3; frame_a(8'hA3);
    @(negedge clk); wr_data_a = 8'h00; frame_a(8'h00);
    @(negedge clk); wr_en_a = 1'b0;
    wait_idle(0);

`ifdef SPART_TXQ_PARITY_EN
    // 0x07 even parity -> 1; mode change mid-frame must not matter
    par_mode_a = 2'b01;
    align(); @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h07; push_vec_a(16'b01110000011, 11);
    @(negedge clk); wr_en_a = 1'b0;
    wait_rate(1); @(negedge clk);
    par_mode_a = 2'b00;
    wait_idle(0);
    par_mode_a = 2'b10;
    align(); @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h07; push_vec_a(16'b01110000001, 11);
    @(negedge clk); wr_en_a = 1'b0;
    wait_idle(0);
    par_mode_a = 2'b00;
`endif

    // five writes into a depth-4 FIFO while idle
    align(); @(negedge clk);
    o0 = ovf_cnt_a;
    wr_en_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data_a = 8'h10 + 8'(i);
      if (i < 4) frame_a(8'h10 + 8'(i));
      @(negedge clk);
    end
    wr_en_a = 1'b0;
    @(negedge clk);
    chk("a_full_level", level_a, 4);
    chk("a_full_tbr", tbr_a, 0);
    chk("a_ovf_pulses", ovf_cnt_a - o0, 1);
    busy_len(0, nb);
    chk("a_burst_busy_cycles", nb, 640);
    wait_idle(0);

    // write coinciding with a pop at level 4 is dropped
    align(); @(negedge clk);
    wr_en_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data_a = 8'h20 + 8'(i); frame_a(8'h20 + 8'(i));
      @(negedge clk);
    end
    wr_en_a = 1'b0;
    chk("a_refill_level", level_a, 4);
    wait_rate(1);
    wr_en_a = 1'b1; wr_data_a = 8'hEE;
    @(negedge clk); wr_en_a = 1'b0;
    chk("a_drop_ovf", ovf_a, 1);
    chk("a_drop_level", level_a, 3);
    chk("a_drop_tbr", tbr_a, 1);
    wait_rate(10);
    wr_en_a = 1'b1; wr_data_a = 8'h5A; frame_a(8'h5A);
    @(negedge clk); wr_en_a = 1'b0;
    chk("a_pushpop_level", level_a, 3);
    chk("a_pushpop_ovf", ovf_a, 0);
    wait_idle(0);

    // reset in the middle of the third data bit
    align(); @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'hC2; frame_a(8'hC2);
    @(negedge clk); wr_data_a = 8'h81; frame_a(8'h81);
    @(negedge clk); wr_en_a = 1'b0;
    wait_rate(1);
    wait_rate(3);
    repeat (8) @(negedge clk);
    chk("a_mid_d2_txd", txd_a, 0);
    chk("a_mid_d2_level", level_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("a_abort_txd", txd_a, 1);
    chk("a_abort_level", level_a, 0);
    chk("a_abort_busy", busy_a, 0);
    chk("a_abort_tbr", tbr_a, 1);
    exp_a.delete();
    @(negedge clk); rst = 1'b0;
    align(); @(negedge clk);
    wr_en_a = 1'b1; wr_data_a = 8'h3C; frame_a(8'h3C);
    @(negedge clk); wr_en_a = 1'b0;
    wait_idle(0);

    // 5-bit characters with two stop bits
    align(); @(negedge clk);
    wr_en_b = 1'b1; wr_data_b = 5'h1F; push_vec_b(16'b01111111, 8);
    @(negedge clk); wr_en_b = 1'b0;
    wait_idle(1);
    align(); @(negedge clk);
    wr_en_b = 1'b1; wr_data_b = 5'h0A; push_vec_b(16'b00101011, 8);
    @(negedge clk); wr_data_b = 5'h15; push_vec_b(16'b01010111, 8);
    @(negedge clk); wr_en_b = 1'b0;
    busy_len(1, nb);
    chk("b_two_frame_busy_cycles", nb, 256);
    wait_idle(1);
    chk("b_idle_txd", txd_b, 1);

    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
